// File: rtl/systolic_pkg.sv
// Shared defaults, FSM state type and saturation limits for the systolic result path.
package systolic_pkg;

    localparam int unsigned N_MACS_DEF = 4;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned FRAC_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_t;

    localparam logic [DATA_W_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W_DEF-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_quant.sv
// Combinational accumulator quantizer: arithmetic shift, optional ReLU, signed saturation.
// RESULT_RELU_EN clamps negative shifted values to zero before saturation.
module sat_quant
    import systolic_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] q
);

    localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] sh;

    always_comb begin
        sh = acc >>> FRAC_W;
`ifdef RESULT_RELU_EN
        if (sh[ACC_W-1]) begin
            sh = '0;
        end
`endif
        if (sh > HI) begin
            q = HI[DATA_W-1:0];
        end else if (sh < LO) begin
            q = LO[DATA_W-1:0];
        end else begin
            q = sh[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/result_mem_wr.sv
// Deskews diagonal systolic outputs, quantizes and packs them into output-memory lines.
// Quantization behaviour depends on RESULT_RELU_EN (see sat_quant).
module result_mem_wr
    import systolic_pkg::*;
#(
    parameter int unsigned N_MACS    = N_MACS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned FRAC_W    = FRAC_W_DEF,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          y_valid,
    input  logic [ACC_W-1:0]              y_0,
    input  logic [ACC_W-1:0]              y_1,
    input  logic [ACC_W-1:0]              y_2,
    input  logic [ACC_W-1:0]              y_3,
    output logic                          busy,
    output logic                          store_done,
    output logic [$clog2(MEM_DEPTH)-1:0]  wr_addr,
    output logic [$clog2(MEM_DEPTH):0]    wr_count,
    output logic                          mem_full,
    output logic                          overrun,
    input  logic [$clog2(MEM_DEPTH)-1:0]  rd_addr,
    output logic [N_MACS*DATA_W-1:0]      rd_data
);

    localparam int unsigned AW     = $clog2(MEM_DEPTH);
    localparam int unsigned CW     = $clog2(N_MACS);
    localparam int unsigned LINE_W = N_MACS * DATA_W;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                cap, we;
    logic [DATA_W-1:0]   slot_q [N_MACS];
    logic [LINE_W-1:0]   line;
    logic [ACC_W-1:0]    lane_sel;
    logic [DATA_W-1:0]   q;
    logic [AW-1:0]       wr_addr_q;
    logic [AW:0]         wr_count_q;
    logic                mem_full_q, overrun_q, store_done_q;
    logic [LINE_W-1:0]   rd_data_q;
    logic [LINE_W-1:0]   mem [MEM_DEPTH];

    // Lane counter selects which skewed input feeds the single quantizer.
    always_comb begin
        lane_sel = y_0;
        case (int'(cnt_q))
            1:       lane_sel = y_1;
            2:       lane_sel = y_2;
            3:       lane_sel = y_3;
            default: lane_sel = y_0;
        endcase
    end

    sat_quant #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_quant (
        .acc (lane_sel),
        .q   (q)
    );

    always_comb begin
        for (int k = 0; k < N_MACS; k++) begin
            line[k*DATA_W +: DATA_W] = slot_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (y_valid) begin
                    cap     = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                cap = 1'b1;
                if (cnt_q == CW'(N_MACS - 1)) begin
                    cnt_d   = '0;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                we      = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // clr aborts any partial line without writing it.
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            cap     = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            store_done_q <= 1'b0;
            wr_addr_q    <= '0;
            wr_count_q   <= '0;
            mem_full_q   <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < N_MACS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_done_q <= we;
            if (cap) begin
                slot_q[cnt_q] <= q;
            end
            if (clr) begin
                wr_addr_q  <= '0;
                wr_count_q <= '0;
                mem_full_q <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                if (y_valid && state_q != IDLE) begin
                    overrun_q <= 1'b1;
                end
                if (we) begin
                    if (wr_addr_q == AW'(MEM_DEPTH - 1)) begin
                        wr_addr_q  <= '0;
                        mem_full_q <= 1'b1;
                    end else begin
                        wr_addr_q <= wr_addr_q + AW'(1);
                    end
                    if (wr_count_q != (AW+1)'(MEM_DEPTH)) begin
                        wr_count_q <= wr_count_q + (AW+1)'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr_q] <= line;
        end
    end

    // Read-before-write: a same-edge address collision returns the old line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign busy       = (state_q != IDLE);
    assign store_done = store_done_q;
    assign wr_addr    = wr_addr_q;
    assign wr_count   = wr_count_q;
    assign mem_full   = mem_full_q;
    assign overrun    = overrun_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_result_mem_wr.sv
// Self-checking bench for result_mem_wr: time-indexed line model plus directed literal checks.
module tb_result_mem_wr;
    import systolic_pkg::*;

    localparam int MD = 4;
    localparam int NL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        y_valid = 1'b0;
    logic [31:0] y_0 = '0, y_1 = '0, y_2 = '0, y_3 = '0;
    logic        busy, store_done, mem_full, overrun;
    logic [1:0]  wr_addr;
    logic [2:0]  wr_count;
    logic [1:0]  rd_addr = '0;
    logic [63:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    result_mem_wr #(
        .N_MACS    (4),
        .DATA_W    (16),
        .ACC_W     (32),
        .FRAC_W    (8),
        .MEM_DEPTH (MD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .y_valid    (y_valid),
        .y_0        (y_0),
        .y_1        (y_1),
        .y_2        (y_2),
        .y_3        (y_3),
        .busy       (busy),
        .store_done (store_done),
        .wr_addr    (wr_addr),
        .wr_count   (wr_count),
        .mem_full   (mem_full),
        .overrun    (overrun),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] quant(input logic [31:0] x);
        longint v;
        logic [63:0] r;
        v = longint'($signed(x)) >>> 8;
`ifdef RESULT_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > longint'($signed(SAT_MAX))) v = longint'($signed(SAT_MAX));
        if (v < longint'($signed(SAT_MIN))) v = longint'($signed(SAT_MIN));
        r = 64'(v);
        return r[15:0];
    endfunction

    function automatic logic [31:0] lane_of(input int k);
        case (k)
            1:       return y_1;
            2:       return y_2;
            3:       return y_3;
            default: return y_0;
        endcase
    endfunction

    // Model: a line accepted at edge p takes lane k from edge p+k and is stored at edge p+NL.
    int          edge_n = 0;
    int          pend = -1;
    logic [15:0] slot_m [NL];
    logic [63:0] mem_m [MD];
    bit          known [MD];
    int          addr_m = 0, cnt_m = 0;
    bit          full_m = 0, ovr_m = 0, done_m = 0, rd_known = 1;
    logic [63:0] rd_m = '0;

    always @(posedge clk or negedge rst_n) begin
        bit was_busy;
        if (!rst_n) begin
            pend = -1; addr_m = 0; cnt_m = 0;
            full_m = 0; ovr_m = 0; done_m = 0;
            rd_m = '0; rd_known = 1;
        end else begin
            rd_known = known[rd_addr];
            rd_m     = mem_m[rd_addr];
            done_m   = 0;
            if (clr) begin
                pend = -1; addr_m = 0; cnt_m = 0; full_m = 0; ovr_m = 0;
            end else begin
                was_busy = (pend >= 0);
                if (pend >= 0 && edge_n - pend < NL) begin
                    slot_m[edge_n - pend] = quant(lane_of(edge_n - pend));
                end else if (pend >= 0) begin
                    mem_m[addr_m] = {slot_m[3], slot_m[2], slot_m[1], slot_m[0]};
                    known[addr_m] = 1;
                    if (addr_m == MD - 1) begin
                        addr_m = 0;
                        full_m = 1;
                    end else begin
                        addr_m++;
                    end
                    if (cnt_m < MD) cnt_m++;
                    done_m = 1;
                    pend = -1;
                end
                if (y_valid) begin
                    if (was_busy) begin
                        ovr_m = 1;
                    end else begin
                        pend = edge_n;
                        slot_m[0] = quant(y_0);
                    end
                end
            end
            edge_n++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("busy", 64'(busy), 64'(pend >= 0));
            check("store_done", 64'(store_done), 64'(done_m));
            check("wr_addr", 64'(wr_addr), 64'(addr_m));
            check("wr_count", 64'(wr_count), 64'(cnt_m));
            check("mem_full", 64'(mem_full), 64'(full_m));
            check("overrun", 64'(overrun), 64'(ovr_m));
            if (rd_known) check("rd_data", rd_data, rd_m);
        end
    end

    task automatic set_lane(input int k, input logic [31:0] v);
        case (k)
            0: y_0 = v;
            1: y_1 = v;
            2: y_2 = v;
            default: y_3 = v;
        endcase
    endtask

    // Drives one skewed line over NL cycles plus the write cycle; extra adds a stray y_valid.
    task automatic send_line(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3, input int extra);
        logic [31:0] a [NL];
        a = '{a0, a1, a2, a3};
        for (int k = 0; k <= NL; k++) begin
            @(negedge clk);
            y_valid = (k == 0) || (k == extra);
            y_0 = 32'h5A5A_0000 + 32'(k);
            y_1 = 32'hA5A5_0000 + 32'(k);
            y_2 = 32'h1234_5600 + 32'(k);
            y_3 = 32'hEDCB_A900 + 32'(k);
            if (k < NL) set_lane(k, a[k]);
        end
        @(negedge clk);
        y_valid = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic readback(input logic [1:0] a, input string name, input logic [63:0] exp);
        @(negedge clk); rd_addr = a;
        @(posedge clk); #1;
        check(name, rd_data, exp);
    endtask

    initial begin
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single line: store_done and the write land on the edge after lane 3 is captured.
        send_line(32'h100, 32'h200, 32'h300, 32'h400, -1);
        check("single_done", 64'(store_done), 64'd1);
        check("single_addr", 64'(wr_addr), 64'd1);
        readback(2'd0, "single_line", 64'h0004_0003_0002_0001);

        send_line(32'h7FFF_FF00, 32'h8000_0000, 32'hFFFF_FF00, 32'h0000_0180, -1);
`ifdef RESULT_RELU_EN
        readback(2'd1, "sat_line", 64'h0001_0000_0000_7FFF);
`else
        readback(2'd1, "sat_line", 64'h0001_FFFF_8000_7FFF);
`endif
        do_clr();
        check("clr_addr", 64'(wr_addr), 64'd0);

        for (int i = 0; i < 3; i++) begin
            send_line(32'((i * 16 + 1) << 8), 32'((i * 16 + 2) << 8),
                      32'((i * 16 + 3) << 8), 32'((i * 16 + 4) << 8), -1);
        end
        @(posedge clk); #1;
        check("b2b_count", 64'(wr_count), 64'd3);
        check("b2b_overrun", 64'(overrun), 64'd0);
        readback(2'd2, "b2b_line2", 64'h0024_0023_0022_0021);
        send_line(32'h0A00, 32'h0B00, 32'h0C00, 32'h0D00, 2);
        @(posedge clk); #1;
        check("ovr_flag", 64'(overrun), 64'd1);
        readback(2'd3, "ovr_line", 64'h000D_000C_000B_000A);

        do_clr();
        for (int i = 0; i < 5; i++) begin
            send_line(32'((32 + i * 16) << 8), 32'((33 + i * 16) << 8),
                      32'((34 + i * 16) << 8), 32'((35 + i * 16) << 8), -1);
            @(posedge clk); #1;
            check("wrap_full", 64'(mem_full), 64'(i >= 3));
        end
        check("wrap_addr", 64'(wr_addr), 64'd1);
        check("wrap_count", 64'(wr_count), 64'd4);
        readback(2'd0, "wrap_line0", 64'h0063_0062_0061_0060);

        // clr at the third capture edge with a coincident y_valid that must be dropped.
        do_clr();
        @(negedge clk); y_valid = 1'b1; y_0 = 32'h7700;
        @(negedge clk); y_valid = 1'b0; y_1 = 32'h7800;
        @(negedge clk); clr = 1'b1; y_valid = 1'b1; y_2 = 32'h7900;
        @(negedge clk); clr = 1'b0; y_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_addr", 64'(wr_addr), 64'd0);
        check("abort_overrun", 64'(overrun), 64'd0);
        readback(2'd0, "abort_mem0", 64'h0063_0062_0061_0060);

        // Async reset mid-capture, after overrun has been raised.
        @(negedge clk); y_valid = 1'b1; y_0 = 32'h4400;
        @(negedge clk); y_valid = 1'b1; y_1 = 32'h4500;
        @(negedge clk); y_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_overrun", 64'(overrun), 64'd0);
        check("arst_rd_data", rd_data, 64'd0);
        check("arst_wr_count", 64'(wr_count), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        send_line(32'h900, 32'hA00, 32'hB00, 32'hC00, -1);
        check("arst_addr", 64'(wr_addr), 64'd1);
        readback(2'd0, "arst_line", 64'h000C_000B_000A_0009);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
